// File: rtl/waveform_gen_pkg.sv
// waveform_gen_pkg: shared state encoding and width helpers for pattern_wave_gen
package waveform_gen_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, HUNT = 2'b01, EMIT = 2'b10} state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction
  function automatic int idx_w(input int wave_len);
    return wave_len > 1 ? $clog2(wave_len) : 1;
  endfunction
endpackage

// File: rtl/pattern_matcher.sv
// pattern_matcher: sample history, saturating valid count and masked compare against the pattern
module pattern_matcher #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift,
  input  logic               clear,
  input  logic               sig_in,
  input  logic               overlap,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  output logic               hit
);
  localparam logic [MAX_LEN:0] ONE = 1;
  logic [MAX_LEN-1:0] hist, hist_nxt, mask;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  assign hist_nxt = MAX_LEN'({hist, sig_in});
  assign cnt_nxt = cnt == LEN_W'(MAX_LEN) ? cnt : cnt + 1'b1;
  assign mask = MAX_LEN'((ONE << length) - 1'b1);
  // hit looks at the history as it will be after this sample is shifted in
  assign hit = shift && length != '0 && cnt_nxt >= length && ((hist_nxt ^ pattern) & mask) == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist <= '0;
      cnt <= '0;
    end else if (clear) begin
      hist <= '0;
      cnt <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      cnt <= hit && !overlap ? '0 : cnt_nxt;
    end
endmodule

// File: rtl/pattern_wave_gen.sv
// pattern_wave_gen: detects a configurable serial pattern and emits a fixed-length waveform per detection
module pattern_wave_gen
  import waveform_gen_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int WAVE_LEN = 16,
  parameter int CNT_W = 8,
  localparam int LEN_W = len_w(MAX_LEN),
  localparam int IDX_W = idx_w(WAVE_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                sig_in,
  input  logic                cfg_load,
  input  logic [MAX_LEN-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [WAVE_LEN-1:0] cfg_wave,
  input  logic                cfg_overlap,
  output logic                sig_out,
  output logic                match,
  output logic                busy,
  output logic                cfg_reject,
  output logic                overrun,
  output logic [CNT_W-1:0]    match_count
);
  state_t state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0] len_q, eff_len;
  logic [WAVE_LEN-1:0] wave_q;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic overlap_q, load_ok, shift, hit, last, sig_d;
  assign load_ok = cfg_load && state_q != EMIT;
  // a load in the same cycle as a sample wins and the sample is dropped
  assign shift = enable && !load_ok && state_q != IDLE;
  assign eff_len = len_q > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len_q;
  assign idx_nxt = idx_q + 1'b1;
  assign last = idx_q == IDX_W'(WAVE_LEN - 1);
  pattern_matcher #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_matcher (
    .clk(clk),
    .rst_n(rst_n),
    .shift(shift),
    .clear(load_ok),
    .sig_in(sig_in),
    .overlap(overlap_q),
    .pattern(pattern_q),
    .length(eff_len),
    .hit(hit)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sig_d = sig_out;
    case (state_q)
      IDLE: state_d = load_ok ? HUNT : IDLE;
      HUNT: if (hit) begin
        state_d = EMIT;
        idx_d = '0;
        sig_d = wave_q[0];
      end
      EMIT: if (enable) begin
        state_d = last ? HUNT : EMIT;
        idx_d = last ? '0 : idx_nxt;
        sig_d = last ? 1'b0 : wave_q[idx_nxt];
      end
      default: begin
        state_d = IDLE;
        idx_d = '0;
        sig_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      sig_out <= 1'b0;
      busy <= 1'b0;
      match <= 1'b0;
      cfg_reject <= 1'b0;
      overrun <= 1'b0;
      match_count <= '0;
      pattern_q <= '0;
      len_q <= '0;
      wave_q <= '0;
      overlap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sig_out <= sig_d;
      busy <= state_d == EMIT;
      match <= hit;
      cfg_reject <= cfg_load && state_q == EMIT;
      overrun <= !load_ok && (overrun || (hit && state_q == EMIT));
      if (hit && !(&match_count)) match_count <= match_count + 1'b1;
      if (load_ok) begin
        pattern_q <= cfg_pattern;
        len_q <= cfg_len;
        wave_q <= cfg_wave;
        overlap_q <= cfg_overlap;
      end
    end
endmodule

// File: doc/pattern_wave_gen.md
PATTERN_WAVE_GEN -- requirements
Module: pattern_wave_gen

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum detectable pattern length in samples.
REQ-002 Parameter WAVE_LEN, default 16: length in samples of the emitted output waveform.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Derived widths: LEN_W = clog2(MAX_LEN)+1; IDX_W = clog2(WAVE_LEN).
REQ-005 Port list:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  sample/advance strobe; no state change when low, except cfg_load.
- sig_in  in  1  serial input sample.
- cfg_load  in  1  load configuration, single-cycle strobe.
- cfg_pattern  in  MAX_LEN  pattern; bit 0 is the most recent sample.
- cfg_len  in  LEN_W  pattern length.
- cfg_wave  in  WAVE_LEN  output waveform; bit 0 is emitted first.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- sig_out  out  1  registered waveform output.
- match  out  1  one-cycle pulse per detected pattern.
- busy  out  1  high while the state is EMIT.
- cfg_reject  out  1  one-cycle pulse when cfg_load is refused.
- overrun  out  1  sticky; a match occurred during EMIT.
- match_count  out  CNT_W  saturating count of matches.

Function
REQ-006 FSM states: IDLE (unconfigured), HUNT, EMIT.
REQ-007 IDLE: ignore sig_in; hold sig_out=0; only cfg_load leaves IDLE, moving to HUNT.
REQ-008 cfg_load in IDLE/HUNT: latch all cfg_* fields; clear history and valid-sample count; clear overrun; go to HUNT.
REQ-009 cfg_load in EMIT: ignore it; pulse cfg_reject next cycle; keep the existing config.
REQ-010 cfg_load together with enable in HUNT: the load wins and the sample is discarded.
REQ-011 Effective length L = min(cfg_len, MAX_LEN).
REQ-012 L = 0: never match.
REQ-013 Each enabled edge in HUNT or EMIT shifts sig_in into history bit 0 and increments the valid count, saturating at MAX_LEN.
REQ-014 Match condition:
- valid count (including the current sample) >= L;
- the low L bits of history after the shift equal the low L bits of the pattern.
REQ-015 Match in HUNT:
- match=1 the following cycle;
- state becomes EMIT with wave index 0;
- sig_out = cfg_wave[0] in that same cycle.
REQ-016 Match in EMIT:
- pulse match and count it;
- set overrun;
- do not restart the waveform.
REQ-017 After any match with cfg_overlap=0, clear the valid count.
REQ-018 After any match with cfg_overlap=1, keep history and count so overlapping matches are possible.
REQ-019 EMIT stepping:
- each enabled edge increments the index and drives sig_out = cfg_wave[index];
- the enabled edge at index WAVE_LEN-1 returns to HUNT with sig_out=0.
- A waveform is therefore exactly WAVE_LEN enabled cycles long.
REQ-020 sig_out=0 in IDLE and HUNT.
REQ-021 sig_out, busy and match are registered outputs.
REQ-022 match_count increments once per match and saturates at 2^CNT_W-1.
REQ-023 match_count is cleared only by reset.
REQ-024 enable low: hold state, index, history and sig_out; the match and cfg_reject pulses still drop after one cycle.

Reset
REQ-025 rst_n low: state=IDLE; cfg registers, history, valid count and index = 0.
REQ-026 rst_n low: sig_out, match, busy, cfg_reject, overrun = 0; match_count = 0.
REQ-027 Reset mid-EMIT aborts the waveform immediately; sig_out falls to 0 asynchronously.

Structure
REQ-028 Shared package waveform_gen_pkg holds:
- state encodings IDLE=2'b00, HUNT=2'b01, EMIT=2'b10;
- the LEN_W and IDX_W width functions.
REQ-029 Sub-module pattern_matcher holds the history shift register, valid count and compare.
- It takes clk, rst_n, shift, clear, pattern and length.
- It outputs a combinational hit.

Verification
REQ-030 Reset, then cfg_load with pattern=4'b1101 (oldest to newest, sampled as 1,1,0,1), L=4, wave=16'h00FF, overlap=0; feed 1,1,0,1 -> match one cycle after the 4th sample; sig_out=1 for 8 cycles then 0 for 8; busy high for 16 cycles.
REQ-031 Overlap=1, pattern 3'b101, L=3; feed 1,0,1,0,1 -> 2 matches; match_count=2; the second match sets overrun with no waveform restart.
REQ-032 Same stream with overlap=0 -> 1 match; match_count=1.
REQ-033 cfg_load during EMIT -> cfg_reject pulses once; the waveform completes unchanged.
REQ-034 enable toggled 1,0,1,0 during EMIT -> sig_out holds during low cycles; the waveform completes after 16 enabled cycles.
REQ-035 Assert rst_n=0 at EMIT index 5 -> sig_out=0 immediately; after release state=IDLE; a pattern fed without cfg_load gives no match.
